// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the data-memory access controller (dm_ctrl).
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_SIZE     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } dm_state_t;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Sub-word stores are replicated across every lane; byte enables pick the live one.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SZ_BYTE: lanes = {4{wdata[7:0]}};
      SZ_HALF: lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/dm_ctrl_load_ext.sv
// Load lane select and zero/sign extension: picks the addressed byte/half of a bus word.
module dm_ctrl_load_ext
  import dm_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        fill;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    fill     = 1'b0;
    data_o   = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        fill   = ~uns_i & byte_sel[7];
        data_o = {{24{fill}}, byte_sel};
      end
      SZ_HALF: begin
        fill   = ~uns_i & half_sel[15];
        data_o = {{16{fill}}, half_sel};
      end
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory access controller: store lane narrowing, load extension, bus handshake.
// Optional bus timeout is built when DM_TIMEOUT_EN is defined.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_uns,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [1:0]  cpu_err_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // Bus handshake: bus_req is high for every REQ cycle with we/addr/be/wdata held
  // stable; the access completes on the first rising edge where bus_req && bus_ack.
  // bus_ack in any other cycle has no effect; bus_rdata is only sampled on that edge.

  dm_state_t   state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] load_data;
  logic        timeout_hit;

  // Empty marker block: elaborates only for an out-of-range timeout configuration.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TO_W)) begin : g_timeout_param_out_of_range
  end

`ifdef DM_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Held at zero outside REQ, so it is already clear on every entry to REQ.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != ST_REQ) begin
      to_cnt_d = '0;
    end else if (!bus_ack) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_hit = (state_q == ST_REQ) && !bus_ack && (to_cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  dm_ctrl_load_ext u_load_ext (
    .size_i    (size_q),
    .uns_i     (uns_q),
    .addr_lo_i (addr_lo_q),
    .rdata_i   (bus_rdata),
    .data_o    (load_data)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_lo_d   = addr_lo_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    cause_d     = cause_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          we_d      = cpu_we;
          size_d    = cpu_size;
          uns_d     = cpu_uns;
          addr_lo_d = cpu_addr[1:0];
          if (cpu_size == SZ_RSVD) begin
            state_d = ST_DONE;
            cause_d = ERR_SIZE;
          end else if (misaligned(cpu_size, cpu_addr[1:0])) begin
            state_d = ST_DONE;
            cause_d = ERR_MISALIGN;
          end else begin
            state_d     = ST_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = cpu_we;
            bus_addr_d  = {cpu_addr[31:2], 2'b00};
            bus_be_d    = byte_enables(cpu_size, cpu_addr[1:0]);
            bus_wdata_d = store_lanes(cpu_size, cpu_wdata);
          end
        end
      end

      ST_REQ: begin
        // An ack in the expiry cycle is checked first, so it completes normally.
        if (bus_ack || timeout_hit) begin
          state_d     = ST_DONE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_be_d    = '0;
          bus_wdata_d = '0;
          if (bus_ack) begin
            cause_d = ERR_NONE;
            if (!we_q) begin
              rdata_d = load_data;
            end
          end else begin
            cause_d = ERR_TIMEOUT;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      addr_lo_q   <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      cause_q     <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_lo_q   <= addr_lo_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      cause_q     <= cause_d;
    end
  end

  assign cpu_busy      = (state_q != ST_IDLE);
  assign cpu_done      = (state_q == ST_DONE);
  assign cpu_err       = (state_q == ST_DONE) && (cause_q != ERR_NONE);
  assign cpu_err_cause = cause_q;
  assign cpu_rdata     = rdata_q;
  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_be        = bus_be_q;
  assign bus_wdata     = bus_wdata_q;

endmodule
